scan_cmd_sequencer: RTL and testbench

- Host-side driver for the serial control unit: accepts 8-bit command words on a parallel valid/ready interface.
- Serializes each command MSB-first onto the unit's data_in while generating the mutually exclusive reset/run/shift/update strobes.
- For ARITH/LOGIC/BUFFER commands, shifts the unit's result back out over data_out and presents it as a parallel response.
- Sits between the test/host logic and control_unit.

---
 rtl/scan_cmd_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_scan_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_cmd_sequencer.sv
// Serializes 8-bit commands onto the control unit's scan port, then reads result bits back into a parallel response.
// The optional macro SEQ_CMD_QUEUE_EN adds a 2-entry command queue with back-to-back issue.
module scan_cmd_sequencer #(
  parameter int RUN_CYCLES = 1,
  parameter int RESP_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           cmd_word,
  input  logic                 clear_req,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 busy,
  output logic                 cu_data_in,
  output logic                 cu_reset,
  output logic                 cu_run,
  output logic                 cu_shift,
  output logic                 cu_update,
  input  logic                 cu_data_out
);
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SHIFT, S_UPDATE, S_RUN, S_READ, S_DONE
  } state_t;

  localparam logic [3:0] RUN_LAST  = 4'(RUN_CYCLES - 1);
  localparam logic [3:0] RESP_LAST = 4'(RESP_BITS - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [RESP_BITS-1:0] sh_q, sh_d, resp_q, resp_d;
  logic                 clr_pend_q, clr_pend_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, resp_valid_q, cu_data_in_q;
  logic                 cu_reset_q, cu_run_q, cu_shift_q, cu_update_q;
  logic                 clr_any, have_cmd, chain_ok;
  logic [7:0]           next_cmd;

  assign clr_any = clear_req | clr_pend_q;

`ifdef SEQ_CMD_QUEUE_EN
  logic [7:0] fifo_q [2];
  logic [1:0] fcnt_q;
  logic       push, pop, wr_hi;

  assign cmd_ready = rdy_q & (fcnt_q != 2'd2);
  assign push      = cmd_valid & cmd_ready;
  // Entering SHIFT only ever happens by issuing a fresh command.
  assign pop       = (state_d == S_SHIFT) & (state_q != S_SHIFT);
  assign wr_hi     = (fcnt_q == 2'd1) & ~pop;
  assign have_cmd  = (fcnt_q != 2'd0) & ~clr_any;
  assign chain_ok  = have_cmd;
  assign next_cmd  = fifo_q[0];
  assign rdy_d     = 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt_q    <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      if (pop) fifo_q[0] <= fifo_q[1];
      if (push) begin
        if (wr_hi) fifo_q[1] <= cmd_word;
        else       fifo_q[0] <= cmd_word;
      end
      fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  assign cmd_ready = rdy_q & ~clr_any;
  assign have_cmd  = cmd_valid & cmd_ready;
  assign chain_ok  = 1'b0;
  assign next_cmd  = cmd_word;
  assign rdy_d     = (state_d == S_IDLE);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    sh_d       = sh_q;
    resp_d     = resp_q;
    clr_pend_d = clr_pend_q | clear_req;
    case (state_q)
      S_IDLE: begin
        if (clr_any) begin
          state_d    = S_CLEAR;
          clr_pend_d = 1'b0;
        end else if (have_cmd) begin
          state_d = S_SHIFT;
          cmd_d   = next_cmd;
          cnt_d   = '0;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      S_SHIFT: begin
        if (cnt_q == 4'd7) begin
          state_d = S_UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_UPDATE: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_d = '0;
          if (cmd_q[7:6] != 2'b00) begin
            state_d = S_READ;
          end else if (chain_ok) begin
            state_d = S_SHIFT;
            cmd_d   = next_cmd;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        // cu_data_out still holds the pre-shift bit at this edge
        sh_d = RESP_BITS'({sh_q, cu_data_out});
        if (cnt_q == RESP_LAST) begin
          state_d = S_DONE;
          resp_d  = sh_d;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        if (chain_ok) begin
          state_d = S_SHIFT;
          cmd_d   = next_cmd;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      sh_q         <= '0;
      resp_q       <= '0;
      clr_pend_q   <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      cu_data_in_q <= 1'b0;
      cu_reset_q   <= 1'b0;
      cu_run_q     <= 1'b0;
      cu_shift_q   <= 1'b0;
      cu_update_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      sh_q         <= sh_d;
      resp_q       <= resp_d;
      clr_pend_q   <= clr_pend_d;
      rdy_q        <= rdy_d;
      busy_q       <= (state_d != S_IDLE);
      resp_valid_q <= (state_d == S_DONE);
      cu_data_in_q <= (state_d == S_SHIFT) & cmd_d[3'd7 - cnt_d[2:0]];
      cu_reset_q   <= (state_d == S_CLEAR);
      cu_run_q     <= (state_d == S_RUN);
      cu_shift_q   <= (state_d == S_SHIFT) | (state_d == S_READ);
      cu_update_q  <= (state_d == S_UPDATE);
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_q;
  assign cu_data_in = cu_data_in_q;
  assign cu_reset   = cu_reset_q;
  assign cu_run     = cu_run_q;
  assign cu_shift   = cu_shift_q;
  assign cu_update  = cu_update_q;
endmodule

// File: tb/tb_scan_cmd_sequencer.sv
// Bench for scan_cmd_sequencer: table vectors, corner sequences and random commands
// checked against a cycle-trace model built from the command protocol.
module tb_scan_cmd_sequencer;
  localparam int RB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cmd_valid, clear_req, cu_data_out;
  logic [7:0]    cmd_word;
  logic          cmd_ready, resp_valid, busy, cu_data_in, cu_reset, cu_run, cu_shift, cu_update;
  logic [RB-1:0] resp_data;

  logic          v3, clr3, dout3;
  logic [7:0]    w3;
  logic          ready3, rv3, busy3, din3, rst3, run3, sh3, upd3;
  logic [RB-1:0] resp3;

  scan_cmd_sequencer #(.RUN_CYCLES(1), .RESP_BITS(RB)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .clear_req(clear_req), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy), .cu_data_in(cu_data_in),
    .cu_reset(cu_reset), .cu_run(cu_run), .cu_shift(cu_shift),
    .cu_update(cu_update), .cu_data_out(cu_data_out));

  scan_cmd_sequencer #(.RUN_CYCLES(3), .RESP_BITS(RB)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(ready3),
    .cmd_word(w3), .clear_req(clr3), .resp_valid(rv3),
    .resp_data(resp3), .busy(busy3), .cu_data_in(din3),
    .cu_reset(rst3), .cu_run(run3), .cu_shift(sh3),
    .cu_update(upd3), .cu_data_out(dout3));

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  // v = {cu_reset, cu_run, cu_shift, cu_update, cu_data_in, resp_valid, busy, cmd_ready}
  typedef struct { logic [7:0] v; int rd; } exp_t;
  exp_t tr[$];

  typedef struct { logic [7:0] cmd; logic [RB-1:0] pat; logic [RB-1:0] exp; int clr; } vec_t;
  vec_t tbl[6];

  function automatic logic [7:0] obs();
    return {cu_reset, cu_run, cu_shift, cu_update, cu_data_in, resp_valid, busy, cmd_ready};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      assert ($countones({cu_reset, cu_run, cu_shift, cu_update}) <= 1 &&
              $countones({rst3, run3, sh3, upd3}) <= 1)
      else begin
        failures++;
        $display("FAIL strobe_onehot actual=%b/%b required=at-most-one",
                 {cu_reset, cu_run, cu_shift, cu_update}, {rst3, run3, sh3, upd3});
      end
    end
  end

  task automatic push_exp(input logic [7:0] v, input int rd);
    exp_t e;
    e.v  = v;
    e.rd = rd;
    tr.push_back(e);
  endtask

  // Expected per-cycle behaviour from the cycle after acceptance (RUN_CYCLES=1).
  task automatic build(input logic [7:0] w, input int clr_at);
    tr.delete();
    for (int i = 0; i < 8; i++) push_exp({4'b0010, w[7-i], 3'b010}, -1);
    push_exp(8'b0001_0010, -1);
    push_exp(8'b0100_0010, -1);
    if (w[7:6] != 2'b00) begin
      for (int j = 0; j < RB; j++) push_exp(8'b0010_0010, j);
      push_exp(8'b0000_0110, -1);
    end
    if (clr_at >= 0) begin
      push_exp(8'b0000_0000, -1);
      push_exp(8'b1000_0010, -1);
    end
    push_exp(8'b0000_0001, -1);
  endtask

  task automatic run_cmd(input logic [7:0] w, input logic [RB-1:0] pat,
                         input logic [RB-1:0] exp_resp, input int clr_at, output int waited);
    waited = 0;
    cmd_valid = 1'b1;
    cmd_word  = w;
    #1;
    while (cmd_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("accept_%02h", w), {31'd0, cmd_ready}, 32'd1);
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_word  = 8'($urandom);
    build(w, clr_at);
    for (int k = 0; k < tr.size(); k++) begin
      chk($sformatf("trace_%02h_cyc%0d", w, k + 1), {24'd0, obs()}, {24'd0, tr[k].v});
      if (tr[k].v[2]) chk($sformatf("resp_done_%02h", w), {27'd0, resp_data}, {27'd0, exp_resp});
      cu_data_out = (tr[k].rd >= 0) ? pat[RB-1-tr[k].rd] : 1'($urandom);
      clear_req   = (clr_at >= 0) && (k == clr_at || k == clr_at + 1);
      if (k < tr.size() - 1) @(negedge clk);
    end
    chk($sformatf("resp_hold_%02h", w), {27'd0, resp_data}, {27'd0, exp_resp});
  endtask

  initial begin
    int waited, first_run, last_run, runs, rv_at;
    logic [RB-1:0] last_resp, pat, expr;
    logic [7:0] w;
    int clr;

    tbl[0] = '{cmd: 8'h1C, pat: 5'b00000, exp: 5'b00000, clr: -1};
    tbl[1] = '{cmd: 8'hD5, pat: 5'b10101, exp: 5'b10101, clr: -1};
    tbl[2] = '{cmd: 8'hA3, pat: 5'b00011, exp: 5'b00011, clr: -1};
    tbl[3] = '{cmd: 8'h07, pat: 5'b11111, exp: 5'b00011, clr: -1};
    tbl[4] = '{cmd: 8'h7E, pat: 5'b11110, exp: 5'b11110, clr: -1};
    tbl[5] = '{cmd: 8'h81, pat: 5'b00001, exp: 5'b00001, clr: -1};

    reset = 1'b0; cmd_valid = 1'b0; cmd_word = 8'h00; clear_req = 1'b0; cu_data_out = 1'b0;
    v3 = 1'b0; w3 = 8'h00; clr3 = 1'b0; dout3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {24'd0, obs()}, 32'd0);
    chk("reset_resp_data", {27'd0, resp_data}, 32'd0);
    chk("reset_ready3", {31'd0, ready3}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    chk("ready_after_reset", {24'd0, obs()}, 32'h01);

    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].cmd, tbl[i].pat, tbl[i].exp, tbl[i].clr, waited);
      @(negedge clk);
    end

    // Reset during SHIFT of 8'h5A discards the command and clears resp_data.
    cmd_valid = 1'b1; cmd_word = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_shift_5a", {31'd0, cu_shift}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("in_reset_%0d", i), {24'd0, obs()}, 32'd0);
    end
    chk("reset_clears_resp", {27'd0, resp_data}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("quiet_after_reset_%0d", i), {24'd0, obs()}, 32'h01);
      @(negedge clk);
    end

    // Clear and command in the same IDLE cycle: clear wins, command goes next cycle.
    clear_req = 1'b1; cmd_valid = 1'b1; cmd_word = 8'h41;
    #1;
    chk("ready_low_on_clear", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("clear_pulse", {24'd0, obs()}, 32'h82);
    clear_req = 1'b0;
    @(negedge clk);
    chk("post_clear_idle", {24'd0, obs()}, 32'h01);
    run_cmd(8'h41, 5'b01110, 5'b01110, -1, waited);
    chk("clear_then_accept_wait", waited, 32'd0);
    @(negedge clk);

    // Clear pulsed during RUN (and READ) of 8'h60: one cu_reset before the next command.
    run_cmd(8'h60, 5'b10011, 5'b10011, 9, waited);
    run_cmd(8'h2B, 5'b01010, 5'b10011, -1, waited);
    chk("next_after_clear_wait", waited, 32'd0);
    last_resp = 5'b10011;

    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        cmd_word = 8'($urandom);
        chk("rand_gap_idle", {24'd0, obs()}, 32'h01);
      end
      w    = 8'($urandom);
      pat  = RB'($urandom);
      clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      expr = (w[7:6] != 2'b00) ? pat : last_resp;
      run_cmd(w, pat, expr, clr, waited);
      last_resp = expr;
      @(negedge clk);
    end

    // RUN_CYCLES=3 instance: three consecutive run cycles, response at T+18.
    chk("ready3_idle", {31'd0, ready3}, 32'd1);
    v3 = 1'b1; w3 = 8'h81;
    @(negedge clk);
    v3 = 1'b0; w3 = 8'hFF;
    runs = 0; first_run = -1; last_run = -1; rv_at = -1;
    for (int n = 1; n <= 30; n++) begin
      if (run3) begin
        runs++;
        if (first_run < 0) first_run = n;
        last_run = n;
      end
      if (rv3) begin
        rv_at = n;
        chk("dut3_resp", {27'd0, resp3}, 32'h1F);
      end
      @(negedge clk);
    end
    chk("dut3_run_count", runs, 32'd3);
    chk("dut3_run_first", first_run, 32'd10);
    chk("dut3_run_span", last_run - first_run, 32'd2);
    chk("dut3_resp_cycle", rv_at, 32'd18);
    chk("dut3_idle_end", {26'd0, busy3, din3, rst3, sh3, upd3, ready3}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
